ascon_perm_ctrl: RTL and testbench



---
 rtl/ascon_perm_pkg.sv | 31 +++
 rtl/ascon_round_const.sv | 19 +
 rtl/ascon_perm_ctrl.sv | 111 +++++++++++
 tb/tb_ascon_perm_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_perm_pkg.sv
// Shared encodings for the ASCON permutation sequencer: FSM states, round counts, nr_sel codes.
package ascon_perm_pkg;

    localparam int unsigned NR_W               = 4;
    localparam int unsigned MAX_ROUNDS_DEFAULT = 12;

    localparam logic [NR_W-1:0] NR_12 = 4'd12;
    localparam logic [NR_W-1:0] NR_8  = 4'd8;
    localparam logic [NR_W-1:0] NR_6  = 4'd6;

    localparam logic [1:0] NR_SEL_12   = 2'b00;
    localparam logic [1:0] NR_SEL_8    = 2'b01;
    localparam logic [1:0] NR_SEL_6    = 2'b10;
    localparam logic [1:0] NR_SEL_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } perm_state_e;

    // Reserved selector falls back to the full permutation.
    function automatic logic [NR_W-1:0] nr_decode(input logic [1:0] sel);
        case (sel)
            NR_SEL_8: nr_decode = NR_8;
            NR_SEL_6: nr_decode = NR_6;
            default:  nr_decode = NR_12;
        endcase
    endfunction

endpackage

// File: rtl/ascon_round_const.sv
// ASCON round constant: index = MAX_ROUNDS - nr + counter, constant = {F - idx, idx}, zero when idle.
module ascon_round_const
    import ascon_perm_pkg::*;
#(
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned MAX_ROUNDS = MAX_ROUNDS_DEFAULT
) (
    input  logic [NR_W-1:0]  nr_q,
    input  logic [CNT_W-1:0] counter,
    input  logic             round_en,
    output logic [7:0]       round_const
);

    logic [3:0] idx;

    assign idx         = 4'(MAX_ROUNDS) - nr_q + 4'(counter);
    assign round_const = round_en ? {4'hF - idx, idx} : 8'h00;

endmodule

// File: rtl/ascon_perm_ctrl.sv
// ASCON permutation sequencer: IDLE -> RUN (nr rounds) -> DONE handshake with the RoundCounter.
// Optional counter cross-check with sticky err port when ASCON_ROUND_CHECK_EN is defined.
module ascon_perm_ctrl
    import ascon_perm_pkg::*;
#(
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned MAX_ROUNDS = MAX_ROUNDS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [1:0]       nr_sel,
    input  logic [CNT_W-1:0] counter,
    output logic             perm_start,
    output logic             perm_ready,
    output logic             round_en,
    output logic [7:0]       round_const,
    output logic             busy,
    output logic             done
`ifdef ASCON_ROUND_CHECK_EN
    ,
    output logic             err
`endif
);

    perm_state_e       state;
    logic [NR_W-1:0]   nr_q;
    logic [CNT_W-1:0]  nr_ext;
    logic              in_range;
    logic              last_round;

    assign nr_ext     = CNT_W'(nr_q);
    assign in_range   = counter < nr_ext;
    // Also catches an out-of-sync counter so RUN can never hang.
    assign last_round = counter >= (nr_ext - CNT_W'(1));
    assign round_en   = (state == ST_RUN) && in_range;

    ascon_round_const #(
        .CNT_W      (CNT_W),
        .MAX_ROUNDS (MAX_ROUNDS)
    ) u_round_const (
        .nr_q        (nr_q),
        .counter     (counter),
        .round_en    (round_en),
        .round_const (round_const)
    );

    // Sequencer with Moore outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            nr_q       <= NR_12;
            perm_start <= 1'b0;
            perm_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        nr_q       <= nr_decode(nr_sel);
                        state      <= ST_RUN;
                        perm_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_round) begin
                        state      <= ST_DONE;
                        perm_ready <= 1'b1;
                        done       <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    perm_start <= 1'b0;
                    perm_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    perm_start <= 1'b0;
                    perm_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

`ifdef ASCON_ROUND_CHECK_EN
    logic [CNT_W-1:0] shadow_q;

    // Shadow round count; any divergence from the external counter is sticky until rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            err      <= 1'b0;
        end else if (state == ST_RUN) begin
            shadow_q <= shadow_q + CNT_W'(1);
            if (shadow_q != counter) begin
                err <= 1'b1;
            end
        end else begin
            shadow_q <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl paired with a behavioural RoundCounter.
module tb_ascon_perm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [1:0] nr_sel = 2'b00;
    logic [4:0] counter;
    logic       perm_start, perm_ready, round_en, busy, done;
    logic [7:0] round_const;
`ifdef ASCON_ROUND_CHECK_EN
    logic       err;
`endif

    logic [4:0] cnt_q;
    logic       force_en = 1'b0;
    logic [4:0] force_val = 5'd0;

    int vec = 0;
    int errs = 0;

    logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    always #5 clk = ~clk;

    // RoundCounter: counts while perm_start, cleared by perm_ready.
    always @(posedge clk) begin
        if (rst || perm_ready) cnt_q <= 5'd0;
        else if (perm_start)   cnt_q <= cnt_q + 5'd1;
    end

    assign counter = force_en ? force_val : cnt_q;

    ascon_perm_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .nr_sel      (nr_sel),
        .counter     (counter),
        .perm_start  (perm_start),
        .perm_ready  (perm_ready),
        .round_en    (round_en),
        .round_const (round_const),
        .busy        (busy),
        .done        (done)
`ifdef ASCON_ROUND_CHECK_EN
        ,
        .err         (err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] outs();
        return {perm_start, perm_ready, busy, done, round_en, round_const};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vec++;
        if (outs() !== 13'h0) begin
            errs++;
            $display("FAIL reset_outputs got=%h want=%h", outs(), 13'h0);
        end
`ifdef ASCON_ROUND_CHECK_EN
        vec++;
        if (err !== 1'b0) begin
            errs++;
            $display("FAIL reset_err got=%b want=0", err);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    // Accept at cycle T, check every RUN cycle, DONE at T+nr+1, idle with counter 0 at T+nr+2.
    task automatic run_perm(input logic [1:0] sel, input int nr);
        logic [12:0] exp;
        req = 1'b1;
        nr_sel = sel;
        tick();
        req = 1'b0;
        nr_sel = sel + 2'd1;
        for (int k = 1; k <= nr; k++) begin
            exp = {5'b10101, rc_tab[12 - nr + k - 1]};
            vec++;
            if (outs() !== exp) begin
                errs++;
                $display("FAIL run_nr%0d_cycle%0d got=%h want=%h", nr, k, outs(), exp);
            end
            tick();
        end
        exp = {5'b11110, 8'h00};
        vec++;
        if (outs() !== exp) begin
            errs++;
            $display("FAIL done_nr%0d got=%h want=%h", nr, outs(), exp);
        end
        tick();
        vec++;
        if ({outs(), counter} !== 18'h0) begin
            errs++;
            $display("FAIL idle_after_nr%0d got=%h/%h want=0/0", nr, outs(), counter);
        end
        nr_sel = 2'b00;
    endtask

    task automatic test_rounds();
        run_perm(2'b00, 12);
        run_perm(2'b01, 8);
        run_perm(2'b10, 6);
        run_perm(2'b11, 12);
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        req = 1'b1;
        nr_sel = 2'b10;
        tick();
        for (int k = 1; k <= 24; k++) begin
            exp = {(k % 8) != 0, (k % 8) == 7, ((k % 8) >= 1) && ((k % 8) <= 6)};
            vec++;
            if ({busy, done, round_en} !== exp) begin
                errs++;
                $display("FAIL b2b_cycle%0d got=%b want=%b", k, {busy, done, round_en}, exp);
            end
            if (k == 24) req = 1'b0;
            tick();
        end
        vec++;
        if (outs() !== 13'h0) begin
            errs++;
            $display("FAIL b2b_idle got=%h want=0", outs());
        end
        nr_sel = 2'b00;
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        req = 1'b1;
        nr_sel = 2'b00;
        tick();
        req = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        vec++;
        if (outs() !== 13'h0) begin
            errs++;
            $display("FAIL abort_outputs got=%h want=0", outs());
        end
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (done) dones++;
        end
        vec++;
        if (dones !== 0) begin
            errs++;
            $display("FAIL abort_no_done got=%0d want=0", dones);
        end
        run_perm(2'b00, 12);
    endtask

    task automatic test_safety_exit();
        req = 1'b1;
        nr_sel = 2'b01;
        tick();
        req = 1'b0;
        force_en = 1'b1;
        force_val = 5'd9;
        #1;
        vec++;
        if ({busy, round_en, round_const} !== {2'b10, 8'h00}) begin
            errs++;
            $display("FAIL safety_gate got=%h want=%h", {busy, round_en, round_const}, {2'b10, 8'h00});
        end
        tick();
        force_en = 1'b0;
        #1;
        vec++;
        if ({done, perm_ready, round_en} !== 3'b110) begin
            errs++;
            $display("FAIL safety_done got=%b want=110", {done, perm_ready, round_en});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_counter_check();
        req = 1'b1;
        nr_sel = 2'b01;
        tick();
        req = 1'b0;
        vec++;
        if (round_const !== 8'hB4) begin
            errs++;
            $display("FAIL chk_first_const got=%h want=b4", round_const);
        end
        tick();
        force_en = 1'b1;
        force_val = 5'd3;
        #1;
        vec++;
        if ({round_en, round_const} !== {1'b1, 8'h87}) begin
            errs++;
            $display("FAIL chk_forced_const got=%h want=187", {round_en, round_const});
        end
        tick();
        force_en = 1'b0;
`ifdef ASCON_ROUND_CHECK_EN
        vec++;
        if (err !== 1'b1) begin
            errs++;
            $display("FAIL chk_err_set got=%b want=1", err);
        end
`endif
        repeat (6) tick();
        vec++;
        if (done !== 1'b1) begin
            errs++;
            $display("FAIL chk_done_t9 got=%b want=1", done);
        end
        tick();
`ifdef ASCON_ROUND_CHECK_EN
        vec++;
        if (err !== 1'b1) begin
            errs++;
            $display("FAIL chk_err_sticky got=%b want=1", err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++;
        if (err !== 1'b0) begin
            errs++;
            $display("FAIL chk_err_cleared got=%b want=0", err);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_rounds();
        test_back_to_back();
        test_reset_abort();
        test_safety_exit();
        test_counter_check();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
